// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: key codes, ALU op codes,
// FSM state encodings and small decode helpers.
package calc_pkg;

    localparam logic [3:0] KEY_DIV = 4'd10;
    localparam logic [3:0] KEY_CLR = 4'd11;
    localparam logic [3:0] KEY_ADD = 4'd12;
    localparam logic [3:0] KEY_SUB = 4'd13;
    localparam logic [3:0] KEY_MUL = 4'd14;
    localparam logic [3:0] KEY_EQ  = 4'd15;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        ST_IN_A = 3'd0,
        ST_IN_B = 3'd1,
        ST_CALC = 3'd2,
        ST_RES  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Smallest r with 2**r >= v (0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k == KEY_DIV) || (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        logic [1:0] op;
        case (k)
            KEY_ADD: op = OP_ADD;
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal digit accumulator: shifts digits in (acc*10+d), rejects a digit
// that would exceed the digit budget or the W-bit range, and supports
// backspace. A clear in the same cycle as a push yields acc = d.
module dec_accum
    import calc_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3,
    localparam int CW    = (clog2(DIGITS + 1) < 1) ? 1 : clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [3:0]    d,
    output logic [W-1:0]  acc,
    output logic [CW-1:0] cnt,
    output logic          full
);

    localparam logic [W+3:0] TEN_X = (W + 4)'(10);
    localparam logic [W-1:0] TEN_W = W'(10);

    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  base_acc;
    logic [CW-1:0] base_cnt;
    logic [W+3:0]  ext;
    logic          push_ok;

    // Next accumulator value: clear first, then either append or drop a digit.
    always_comb begin
        base_acc = clr ? '0 : acc_q;
        base_cnt = clr ? '0 : cnt_q;
        ext      = {4'b0000, base_acc} * TEN_X + {{W{1'b0}}, d};
        push_ok  = push && (base_cnt != CW'(DIGITS)) && (ext[W+3:W] == 4'b0000);
        acc_d    = base_acc;
        cnt_d    = base_cnt;
        if (push_ok) begin
            acc_d = ext[W-1:0];
            cnt_d = base_cnt + CW'(1);
        end else if (pop && (base_cnt != '0)) begin
            acc_d = base_acc / TEN_W;
            cnt_d = base_cnt - CW'(1);
        end
    end

    // Accumulator and digit-count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc  = acc_q;
    assign cnt  = cnt_q;
    assign full = (cnt_q == CW'(DIGITS));

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: operand entry, operator latching, ALU start/done
// handshake with timeout, result chaining and a sticky error state.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int W       = 8,
    parameter int DIGITS  = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           key_valid,
    input  logic [3:0]     key_code,
    input  logic [W-1:0]   sw_val,
    output logic           alu_start,
    output logic [1:0]     alu_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic           alu_done,
    input  logic           alu_err,
    input  logic [2*W-1:0] alu_result,
    output logic [2*W-1:0] disp_data,
    output logic           err,
    output logic [2:0]     state_o
);

    localparam int CW = (clog2(DIGITS + 1) < 1) ? 1 : clog2(DIGITS + 1);
    localparam int TW = (clog2(TIMEOUT) < 1) ? 1 : clog2(TIMEOUT);
    localparam logic [2*W-1:0] BUSY = {{W{1'b0}}, {(W/4){4'hC}}};

    state_t         state_q, state_d;
    logic [W-1:0]   alu_a_q, alu_a_d;
    logic [W-1:0]   alu_b_q, alu_b_d;
    logic [1:0]     alu_op_q, alu_op_d;
    logic           start_q, start_d;
    logic [2*W-1:0] result_q, result_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic           acc_clr, acc_push, acc_pop, acc_full;
    logic [W-1:0]   acc;
    logic [CW-1:0]  acc_cnt;

    logic           sw_active;
    logic [W-1:0]   cur;
    logic           kv_digit, kv_op, kv_clr, kv_eq;

    assign sw_active = (sw_val != '0);
    assign cur       = sw_active ? sw_val : acc;
    assign kv_digit  = key_valid && is_digit(key_code);
    assign kv_op     = key_valid && is_op(key_code);
    assign kv_clr    = key_valid && (key_code == KEY_CLR);
    assign kv_eq     = key_valid && (key_code == KEY_EQ);

    dec_accum #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .push  (acc_push),
        .pop   (acc_pop),
        .d     (key_code),
        .acc   (acc),
        .cnt   (acc_cnt),
        .full  (acc_full)
    );

    // Next-state, operand latching and accumulator control.
    always_comb begin
        state_d  = state_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        start_d  = 1'b0;
        result_d = result_q;
        timer_d  = timer_q;
        acc_clr  = sw_active;
        acc_push = 1'b0;
        acc_pop  = 1'b0;
        case (state_q)
            ST_IN_A: begin
                if (kv_clr) begin
                    acc_clr = 1'b1;
                end else if (kv_op) begin
                    alu_a_d  = cur;
                    alu_op_d = key_to_op(key_code);
                    acc_clr  = 1'b1;
                    state_d  = ST_IN_B;
                end else if (kv_eq) begin
                    acc_pop = (acc_cnt != '0);
                end else if (kv_digit) begin
                    acc_push = !sw_active && !acc_full;
                end
            end
            ST_IN_B: begin
                if (kv_clr) begin
                    acc_clr = 1'b1;
                    state_d = ST_IN_A;
                end else if (kv_op) begin
                    alu_op_d = key_to_op(key_code);
                end else if (kv_eq) begin
                    alu_b_d = cur;
                    start_d = 1'b1;
                    acc_clr = 1'b1;
                    timer_d = '0;
                    state_d = ST_CALC;
                end else if (kv_digit) begin
                    acc_push = !sw_active && !acc_full;
                end
            end
            ST_CALC: begin
                // alu_done outranks any key; keys are never acted on here.
                if (alu_done) begin
                    if (alu_err) begin
                        state_d = ST_ERR;
                    end else begin
                        result_d = alu_result;
                        state_d  = ST_RES;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RES: begin
                if (kv_clr) begin
                    acc_clr = 1'b1;
                    state_d = ST_IN_A;
                end else if (kv_digit && !sw_active) begin
                    acc_clr  = 1'b1;
                    acc_push = 1'b1;
                    state_d  = ST_IN_A;
                end else if (kv_op) begin
                    alu_a_d  = result_q[W-1:0];
                    alu_op_d = key_to_op(key_code);
                    acc_clr  = 1'b1;
                    state_d  = ST_IN_B;
                end else if (kv_eq) begin
                    alu_a_d = result_q[W-1:0];
                    start_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_CALC;
                end
            end
            ST_ERR: begin
                if (kv_clr) begin
                    acc_clr = 1'b1;
                    state_d = ST_IN_A;
                end
            end
            default: begin
                state_d = ST_IN_A;
            end
        endcase
    end

    // Control and operand registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IN_A;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= OP_ADD;
            start_q  <= 1'b0;
            result_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            start_q  <= start_d;
            result_q <= result_d;
            timer_q  <= timer_d;
        end
    end

    // Display source selected by the current state.
    always_comb begin
        disp_data = '0;
        case (state_q)
            ST_IN_A, ST_IN_B: disp_data = {{W{1'b0}}, cur};
            ST_CALC:          disp_data = BUSY;
            ST_RES:           disp_data = result_q;
            ST_ERR:           disp_data = '1;
            default:          disp_data = '0;
        endcase
    end

    assign alu_start = start_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign err       = (state_q == ST_ERR);
    assign state_o   = state_q;

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
Parametrised calculator sequencer: key-driven operand entry, operator latching, ALU start/done handshake, result chaining and error recovery. Generalises the fixed 8-bit calculator controller in operand width and entry digit count. Adds decimal entry overflow protection, backspace, an ALU timeout and a sticky error state. It sits between the key decoder and the ALU/display/LED drivers in the calculator top level.

Parameters:
W, 8, operand width in bits; result and display width is 2W.
DIGITS, 3, maximum decimal digits accepted per operand.
TIMEOUT, 1024, clk cycles allowed between alu_start and alu_done before an error is raised.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
key_valid  in  1  one-cycle strobe: key_code is valid
key_code  in  4  0-9 digit, 10 DIV, 11 CLEAR, 12 PLUS, 13 MINUS, 14 MUL, 15 EQ/backspace (see Behaviour)
sw_val  in  W  switch operand; non-zero overrides keyed entry
alu_start  out  1  one-cycle start pulse
alu_op  out  2  0 add, 1 sub, 2 mul, 3 div
alu_a  out  W  latched operand A
alu_b  out  W  latched operand B
alu_done  in  1  one-cycle completion pulse
alu_err  in  1  qualified by alu_done; divide-by-zero
alu_result  in  2W  result, qualified by alu_done
disp_data  out  2W  value to display
err  out  1  high while in ERR
state_o  out  3  current state encoding, for LED driver

Behaviour:
- Reset (synchronous, active-low): all outputs are 0, state is IN_A, accumulator is 0, digit count is 0.
- States and encodings: IN_A=0, IN_B=1, CALC=2, RES=3, ERR=4.
- Operand source:
  - cur = sw_val when sw_val != 0; otherwise cur = acc.
  - While sw_val != 0, digit keys are ignored and acc is held at 0.
- Digit entry (key 0-9, IN_A or IN_B):
  - acc <= acc*10 + d, computed at W+4 bits; cnt++.
  - The key is ignored (no change to acc or cnt) if cnt == DIGITS or the result exceeds 2^W-1.
- CLEAR:
  - In IN_A: acc and cnt are cleared.
  - In IN_B: acc and cnt are cleared and state returns to IN_A.
  - In RES or ERR: acc and cnt are cleared and state goes to IN_A.
  - Ignored in CALC.
- IN_A:
  - disp_data = zero-extended cur.
  - An operator key latches alu_a <= cur and alu_op, clears acc and cnt, and moves to IN_B.
  - EQ acts as backspace: acc <= acc/10, cnt-- (no effect when cnt == 0).
- IN_B:
  - disp_data = zero-extended cur.
  - EQ latches alu_b <= cur, pulses alu_start for exactly 1 cycle (the cycle after EQ), clears acc and cnt, and moves to CALC.
  - An operator key replaces alu_op and stays in IN_B.
- CALC:
  - disp_data = {W/4{4'hC}} (busy pattern).
  - Keys are ignored. A timer counts from 0.
  - alu_done with alu_err=0: latch the result, disp_data <= alu_result, go to RES.
  - alu_done with alu_err=1, or timer == TIMEOUT-1: go to ERR.
- RES:
  - disp_data holds the latched result.
  - A digit starts a new A: acc = d, cnt = 1, go to IN_A.
  - An operator sets alu_a <= result[W-1:0] and alu_op, and goes to IN_B (chaining).
  - EQ repeats the last operation: alu_a <= result[W-1:0], alu_b unchanged, alu_start is pulsed, go to CALC.
- ERR:
  - err = 1; disp_data = all ones (2^(2W)-1).
  - Only CLEAR exits. alu_done arriving here is ignored.
- Simultaneous events: alu_done and key_valid in the same CALC cycle → alu_done wins and the key is dropped.
- Reset mid-CALC: the controller returns to IN_A; a late alu_done arriving in IN_A is ignored.
- alu_start is never asserted in two consecutive cycles.

Decomposition:
- Shared package calc_pkg holds:
  - key code localparams: KEY_DIV=10, KEY_CLR=11, KEY_ADD=12, KEY_SUB=13, KEY_MUL=14, KEY_EQ=15;
  - op codes and state encodings;
  - the width helper clog2 for the timeout counter.
- One sub-module: dec_accum, the digit accumulator with its overflow check, backspace and count.
  - Ports: clk, rst_n, clr, push, pop, d, acc, cnt, full.

Test Plan:
- W=8, DIGITS=3: keys 2,5,5,PLUS,1,0,EQ; ALU returns 265 → alu_a=255, alu_b=10, alu_op=0, one alu_start pulse, disp_data=265, state RES.
- Keys 2,5,6 → third digit ignored, acc=25; then 9,9,9,9 after CLEAR → acc=99 after the 4th key is rejected (the 999 entry would overflow).
- Keys 7,DIV,0,EQ; ALU returns done with alu_err=1 → state ERR, err=1, disp_data=16'hFFFF; CLEAR → IN_A, err=0.
- Keys 4,MUL,3,EQ with alu_done withheld for TIMEOUT cycles → ERR exactly at cycle TIMEOUT after alu_start.
- Chaining: from RES with result 12, press SUB,5,EQ → alu_a=12, alu_b=5, alu_op=1; then EQ in RES → alu_a=7, alu_b=5, alu_start pulses again.
- Hold rst_n=0 for 1 cycle mid-CALC, then deliver alu_done → state stays IN_A, all outputs 0, disp_data not updated.
